// File: rtl/osc_capture_pkg.sv
// Shared types and sizes for the oscilloscope capture path (sequencer and display side).
package osc_capture_pkg;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned TO_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_ARMED   = 3'd2,
        ST_POST    = 3'd3,
        ST_HOLD    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'd0,
        MODE_NORMAL = 2'd1,
        MODE_SINGLE = 2'd2,
        MODE_STOP   = 2'd3
    } mode_e;

endpackage

// File: rtl/trigger_detect.sv
// Edge detector: compares each accepted sample with the previous one of the same acquisition.
module trigger_detect #(
    parameter int unsigned DATA_W = osc_capture_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] level,
    input  logic              slope,
    output logic              hit_c
);

    logic [DATA_W-1:0] prev;
    logic              prev_valid;

    // Previous-sample history, dropped at the start of every acquisition
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (clear) begin
            prev_valid <= 1'b0;
        end else if (sample_en) begin
            prev       <= sample;
            prev_valid <= 1'b1;
        end
    end

    always_comb begin
        hit_c = 1'b0;
        if (prev_valid) begin
            if (slope) begin
                hit_c = (prev > level) && (sample <= level);
            end else begin
                hit_c = (prev < level) && (sample >= level);
            end
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// Acquisition sequencer: fills the ring buffer around a trigger and hands the frame to the display.
module capture_sequencer #(
    parameter int unsigned DATA_W = osc_capture_pkg::DATA_W,
    parameter int unsigned DEPTH  = osc_capture_pkg::DEPTH,
    parameter int unsigned ADDR_W = osc_capture_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] trigger_level,
    input  logic              slope,
    input  logic [1:0]        mode,
    input  logic              arm,
    input  logic [ADDR_W-1:0] pre_count,
    input  logic [15:0]       auto_timeout,
    input  logic              frame_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_ready,
    output logic [ADDR_W-1:0] frame_start,
    output logic              triggered,
    output logic [2:0]        state_dbg
);

    import osc_capture_pkg::*;

    localparam int unsigned TOC_W = TO_W + 1;

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_PREFILL = ST_PREFILL;
    localparam logic [2:0] S_ARMED   = ST_ARMED;
    localparam logic [2:0] S_POST    = ST_POST;
    localparam logic [2:0] S_HOLD    = ST_HOLD;

    logic [2:0]        state, next_state;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] pre_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [TO_W-1:0]   to_cnt;

    logic [DATA_W-1:0] cfg_level;
    logic              cfg_slope;
    logic [ADDR_W-1:0] cfg_pre;
    logic [TO_W-1:0]   cfg_timeout;

    logic accept_c, start_c, trig_c, forced_c, hit_c, stop_c, timeout_c;

    trigger_detect #(.DATA_W(DATA_W)) u_trigger_detect (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_c),
        .sample_en (accept_c),
        .sample    (sample_data),
        .level     (cfg_level),
        .slope     (cfg_slope),
        .hit_c     (hit_c)
    );

    assign stop_c    = (mode == MODE_STOP);
    assign timeout_c = (mode == MODE_AUTO) && (cfg_timeout != '0) &&
                       (TOC_W'(to_cnt) + TOC_W'(1) == TOC_W'(cfg_timeout));

    // Next-state and per-cycle strobes
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        start_c    = 1'b0;
        trig_c     = 1'b0;
        forced_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if ((mode == MODE_AUTO) || (mode == MODE_NORMAL) || ((mode == MODE_SINGLE) && arm)) begin
                    start_c = 1'b1;
                end
            end
            S_PREFILL: begin
                if (stop_c) begin
                    next_state = S_IDLE;
                end else if (sample_valid) begin
                    accept_c = 1'b1;
                    if (pre_cnt == cfg_pre - ADDR_W'(1)) begin
                        next_state = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (stop_c) begin
                    next_state = S_IDLE;
                end else if (sample_valid) begin
                    accept_c = 1'b1;
                    if (hit_c) begin
                        trig_c = 1'b1;
                    end else if (timeout_c) begin
                        trig_c   = 1'b1;
                        forced_c = 1'b1;
                    end
                    if (trig_c) begin
                        next_state = (cfg_pre == ADDR_W'(DEPTH - 1)) ? S_HOLD : S_POST;
                    end
                end
            end
            S_POST: begin
                if (stop_c) begin
                    next_state = S_IDLE;
                end else if (sample_valid) begin
                    accept_c = 1'b1;
                    if (post_cnt == ADDR_W'(1)) begin
                        next_state = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (frame_ready && frame_ack) begin
                    if ((mode == MODE_SINGLE) || stop_c) begin
                        next_state = S_IDLE;
                    end else begin
                        start_c = 1'b1;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
        // A zero pre-trigger window skips the prefill phase entirely
        if (start_c) begin
            next_state = (pre_count == '0) ? S_ARMED : S_PREFILL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Configuration snapshot and per-acquisition counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_level   <= '0;
            cfg_slope   <= 1'b0;
            cfg_pre     <= '0;
            cfg_timeout <= '0;
            pre_cnt     <= '0;
            to_cnt      <= '0;
            post_cnt    <= '0;
        end else begin
            if (start_c) begin
                cfg_level   <= trigger_level;
                cfg_slope   <= slope;
                cfg_pre     <= pre_count;
                cfg_timeout <= auto_timeout;
                pre_cnt     <= '0;
                to_cnt      <= '0;
            end else if (accept_c && (state == S_PREFILL)) begin
                pre_cnt <= pre_cnt + ADDR_W'(1);
            end else if (accept_c && (state == S_ARMED)) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (trig_c) begin
                post_cnt <= ADDR_W'(DEPTH - 1) - cfg_pre;
            end else if (accept_c && (state == S_POST)) begin
                post_cnt <= post_cnt - ADDR_W'(1);
            end
        end
    end

    // RAM write port and frame descriptor
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr        <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_ready <= 1'b0;
            frame_start <= '0;
            triggered   <= 1'b0;
        end else begin
            wr_en <= accept_c;
            if (accept_c) begin
                wr_addr <= wptr;
                wr_data <= sample_data;
                wptr    <= wptr + ADDR_W'(1);
            end
            if (trig_c) begin
                frame_start <= wptr - cfg_pre;
                triggered   <= ~forced_c;
            end
            frame_ready <= (state == S_HOLD) && (next_state == S_HOLD);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: trigger, wrap, auto timeout, handshake, single mode, reset.
module tb_capture_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic [11:0] trigger_level;
    logic        slope;
    logic [1:0]  mode;
    logic        arm;
    logic [7:0]  pre_count;
    logic [15:0] auto_timeout;
    logic        frame_ack;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [11:0] wr_data;
    logic        frame_ready;
    logic [7:0]  frame_start;
    logic        triggered;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int w0, trig_k, hold_k;
    logic       trig_seen, seen_rdy;
    logic [7:0]  trig_addr;
    logic [11:0] trig_data;

    capture_sequencer #(.DATA_W(12), .DEPTH(256), .ADDR_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .trigger_level (trigger_level),
        .slope         (slope),
        .mode          (mode),
        .arm           (arm),
        .pre_count     (pre_count),
        .auto_timeout  (auto_timeout),
        .frame_ack     (frame_ack),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .frame_ready   (frame_ready),
        .frame_start   (frame_start),
        .triggered     (triggered),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sample every 4 cycles; remembers where the FSM entered POST
    task automatic send(input logic [11:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
        if (!trig_seen && state_dbg == 3'd3) begin
            trig_seen = 1'b1;
            trig_addr = wr_addr;
            trig_data = wr_data;
        end
        sample_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic run_ramp(input string tag, input int exp_trig, input int exp_start, input int exp_last);
        int base;
        trig_seen = 1'b0;
        base = wr_cnt;
        for (int i = 0; i < 255; i++) send(12'(i * 128));
        sample_valid = 1'b1;
        sample_data  = 12'(255 * 128);
        tick();
        chk({tag, "_last_addr"}, 32'(wr_addr), exp_last);
        chk({tag, "_ready_lag"}, 32'(frame_ready), 0);
        chk({tag, "_state_hold"}, 32'(state_dbg), 4);
        sample_valid = 1'b0;
        tick();
        chk({tag, "_ready"}, 32'(frame_ready), 1);
        chk({tag, "_frame_start"}, 32'(frame_start), exp_start);
        chk({tag, "_triggered"}, 32'(triggered), 1);
        chk({tag, "_trig_addr"}, 32'(trig_addr), exp_trig);
        chk({tag, "_trig_data"}, 32'(trig_data), 2048);
        chk({tag, "_writes"}, 32'(wr_cnt - base), 256);
    endtask

    initial begin
        rst = 1'b1;
        sample_valid = 1'b0;
        sample_data = '0;
        trigger_level = '0;
        slope = 1'b0;
        mode = 2'd3;
        arm = 1'b0;
        pre_count = '0;
        auto_timeout = '0;
        frame_ack = 1'b0;
        trig_seen = 1'b0;
        trig_addr = '0;
        trig_data = '0;

        // Reset asserted before any clock edge
        #2 rst = 1'b0;
        #2;
        chk("reset_wr_en", 32'(wr_en), 0);
        chk("reset_wr_addr", 32'(wr_addr), 0);
        chk("reset_frame_ready", 32'(frame_ready), 0);
        chk("reset_frame_start", 32'(frame_start), 0);
        chk("reset_state", 32'(state_dbg), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        chk("stop_idle", 32'(state_dbg), 0);

        // Normal trigger from pointer 0
        trigger_level = 12'd2048;
        slope = 1'b0;
        pre_count = 8'd16;
        mode = 2'd1;
        tick();
        chk("normal_prefill", 32'(state_dbg), 1);
        run_ramp("normal", 16, 0, 255);

        // Frame held while ack is low, samples ignored
        sample_valid = 1'b1;
        sample_data = 12'd77;
        w0 = wr_cnt;
        repeat (1000) tick();
        chk("hold_no_writes", 32'(wr_cnt - w0), 0);
        chk("hold_ready", 32'(frame_ready), 1);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("ack_ready_fall", 32'(frame_ready), 0);
        chk("ack_prefill", 32'(state_dbg), 1);
        tick();
        chk("resume_wr_en", 32'(wr_en), 1);
        chk("resume_addr", 32'(wr_addr), 0);

        // Stop aborts the acquisition
        sample_valid = 1'b0;
        mode = 2'd3;
        tick();
        chk("stop_abort", 32'(state_dbg), 0);

        // Move the pointer to 245 with an untriggerable prefill, then stop
        pre_count = 8'd255;
        mode = 2'd1;
        tick();
        sample_valid = 1'b1;
        repeat (244) tick();
        sample_valid = 1'b0;
        mode = 2'd3;
        tick();
        chk("filler_idle", 32'(state_dbg), 0);
        w0 = wr_cnt;
        repeat (5) tick();
        chk("stop_no_writes", 32'(wr_cnt - w0), 0);

        // Wrap: trigger at 245+16 = 5, frame_start = 5-16 = 245
        pre_count = 8'd16;
        mode = 2'd1;
        tick();
        run_ramp("wrap", 5, 245, 244);

        // Single mode returns to IDLE and waits for arm
        mode = 2'd2;
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("single_idle", 32'(state_dbg), 0);
        chk("single_ready_fall", 32'(frame_ready), 0);
        w0 = wr_cnt;
        repeat (5) send(12'd3000);
        chk("single_no_writes", 32'(wr_cnt - w0), 0);
        chk("single_still_idle", 32'(state_dbg), 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("single_armed", 32'(state_dbg), 1);
        run_ramp("single", 5, 245, 244);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("single_done_idle", 32'(state_dbg), 0);

        // Auto timeout: pointer 245, forced trigger on the 50th sample at address 38
        mode = 2'd0;
        pre_count = 8'd0;
        auto_timeout = 16'd50;
        tick();
        chk("auto_armed", 32'(state_dbg), 2);
        trig_seen = 1'b0;
        trig_k = 0;
        hold_k = 0;
        sample_data = 12'd100;
        sample_valid = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (!trig_seen && state_dbg == 3'd3) begin
                trig_seen = 1'b1;
                trig_k = k;
                trig_addr = wr_addr;
            end
            if (state_dbg == 3'd4) begin
                hold_k = k;
                break;
            end
        end
        sample_valid = 1'b0;
        chk("auto_trig_k", 32'(trig_k), 50);
        chk("auto_trig_addr", 32'(trig_addr), 38);
        chk("auto_hold_k", 32'(hold_k), 305);
        tick();
        chk("auto_ready", 32'(frame_ready), 1);
        chk("auto_triggered", 32'(triggered), 0);
        chk("auto_frame_start", 32'(frame_start), 38);

        // Normal mode with the same flat input never triggers
        mode = 2'd1;
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("normal_flat_armed", 32'(state_dbg), 2);
        seen_rdy = 1'b0;
        sample_valid = 1'b1;
        repeat (10000) begin
            tick();
            if (frame_ready !== 1'b0) seen_rdy = 1'b1;
        end
        chk("normal_no_frame", 32'(seen_rdy), 0);
        chk("normal_flat_state", 32'(state_dbg), 2);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("ack_ignored", 32'(state_dbg), 2);

        // Async reset in the middle of POST
        sample_data = 12'd3000;
        tick();
        chk("post_entered", 32'(state_dbg), 3);
        sample_data = 12'd100;
        repeat (10) tick();
        chk("post_wr_en", 32'(wr_en), 1);
        #1 rst = 1'b0;
        #1;
        chk("arst_wr_en", 32'(wr_en), 0);
        chk("arst_wr_addr", 32'(wr_addr), 0);
        chk("arst_wr_data", 32'(wr_data), 0);
        chk("arst_frame_start", 32'(frame_start), 0);
        chk("arst_triggered", 32'(triggered), 0);
        chk("arst_state", 32'(state_dbg), 0);
        sample_valid = 1'b0;
        pre_count = 8'd16;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("restart_prefill", 32'(state_dbg), 1);
        sample_valid = 1'b1;
        sample_data = 12'd5;
        tick();
        sample_valid = 1'b0;
        chk("restart_wr_en", 32'(wr_en), 1);
        chk("restart_addr", 32'(wr_addr), 0);
        chk("restart_data", 32'(wr_data), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
